wb_cache: RTL and testbench

WB_CACHE -- requirements
Module: wb_cache

---
 rtl/wb_cache.sv | 254 +++++++++++++++++++++++++
 tb/tb_wb_cache.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cache.sv
// wb_cache: write-back, write-allocate cache with 16-word lines and 128-bit memory beats.
// Define WB_CACHE_PERF_EN to add the perf_hits/perf_misses/perf_writebacks counters.
module wb_cache #(
    parameter int LINES          = 64,
    parameter int WAYS           = 2,
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
    input  logic [CPU_WIDTH-1:0]      cpu_req_data,
    input  logic [CPU_WIDTH/8-1:0]    cpu_req_write,
    output logic                      cpu_resp_valid,
    output logic [CPU_WIDTH-1:0]      cpu_resp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_rw,
    output logic [WORD_ADDR_BITS-3:0] mem_req_addr,
    output logic                      mem_req_data_valid,
    input  logic                      mem_req_data_ready,
    output logic [127:0]              mem_req_data_bits,
    output logic [15:0]               mem_req_data_mask,
    input  logic                      mem_resp_valid,
    input  logic [127:0]              mem_resp_data
`ifdef WB_CACHE_PERF_EN
    ,
    output logic [31:0]               perf_hits,
    output logic [31:0]               perf_misses,
    output logic [31:0]               perf_writebacks
`endif
);

    localparam int SETS  = LINES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_ADDR_BITS - 4 - IDX_W;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, REPLAY
    } state_t;

    state_t state;

    logic [127:0]         data_q  [WAYS][SETS][4];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];

    logic [WORD_ADDR_BITS-1:0] req_addr_q;
    logic [CPU_WIDTH-1:0]      req_data_q;
    logic [CPU_WIDTH/8-1:0]    req_we_q;
    logic [IDX_W-1:0]          init_cnt;
    logic [1:0]                beat_cnt;
    logic                      vic_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       req_beat;
    logic [1:0]       req_word;
    logic             hit, hit_way, victim, lru_rd;
    logic             acc_way, do_acc;
    logic [127:0]     acc_beat;
    logic [3:0][CPU_WIDTH-1:0]          beat_words;
    logic [3:0][CPU_WIDTH/8-1:0][7:0]   merged;
    logic             lru_we, lru_wd;
    logic [IDX_W-1:0] lru_idx;

    assign req_idx  = req_addr_q[4 +: IDX_W];
    assign req_tag  = req_addr_q[WORD_ADDR_BITS-1 -: TAG_W];
    assign req_beat = req_addr_q[3:2];
    assign req_word = req_addr_q[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        victim  = lru_rd;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
        // Lowest-numbered invalid way wins over the LRU choice.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = 1'(w);
        end
    end

    assign acc_way    = (state == REPLAY) ? vic_q : hit_way;
    assign do_acc     = (state == LOOKUP && hit) || state == REPLAY;
    assign acc_beat   = data_q[acc_way][req_idx][req_beat];
    assign beat_words = acc_beat;

    always_comb begin
        merged = acc_beat;
        for (int b = 0; b < CPU_WIDTH/8; b++) begin
            if (req_we_q[b]) merged[req_word][b] = req_data_q[8*b +: 8];
        end
    end

    always_comb begin
        lru_we  = 1'b0;
        lru_wd  = 1'b0;
        lru_idx = req_idx;
        if (state == INIT) begin
            lru_we  = 1'b1;
            lru_idx = init_cnt;
        end else if (do_acc) begin
            lru_we = 1'b1;
            lru_wd = ~acc_way;
        end
    end

    // LRU bit names the way to evict next.
    generate
        if (WAYS == 2) begin : g_lru
            logic lru_q [SETS];
            always_ff @(posedge clk) begin
                if (lru_we) lru_q[lru_idx] <= lru_wd;
            end
            assign lru_rd = lru_q[req_idx];
        end else begin : g_nolru
            assign lru_rd = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= INIT;
            init_cnt           <= '0;
            beat_cnt           <= '0;
            cpu_req_ready      <= 1'b0;
            cpu_resp_valid     <= 1'b0;
            cpu_resp_data      <= '0;
            mem_req_valid      <= 1'b0;
            mem_req_rw         <= 1'b0;
            mem_req_addr       <= '0;
            mem_req_data_valid <= 1'b0;
            mem_req_data_bits  <= '0;
            mem_req_data_mask  <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            unique case (state)
                INIT: begin
                    valid_q[init_cnt] <= '0;
                    dirty_q[init_cnt] <= '0;
                    init_cnt          <= init_cnt + 1'b1;
                    if (init_cnt == IDX_W'(SETS - 1)) begin
                        state         <= IDLE;
                        cpu_req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_addr_q    <= cpu_req_addr;
                        req_data_q    <= cpu_req_data;
                        req_we_q      <= cpu_req_write;
                        cpu_req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP, REPLAY: begin
                    if (do_acc) begin
                        if (req_we_q == '0) begin
                            cpu_resp_valid <= 1'b1;
                            cpu_resp_data  <= beat_words[req_word];
                        end else begin
                            data_q[acc_way][req_idx][req_beat] <= merged;
                            dirty_q[req_idx][acc_way]          <= 1'b1;
                        end
                        state         <= IDLE;
                        cpu_req_ready <= 1'b1;
                    end else begin
                        vic_q         <= victim;
                        mem_req_valid <= 1'b1;
                        if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            state        <= WB_CMD;
                            mem_req_rw   <= 1'b1;
                            mem_req_addr <= {tag_q[victim][req_idx], req_idx, 2'b00};
                        end else begin
                            state        <= FILL_CMD;
                            mem_req_rw   <= 1'b0;
                            mem_req_addr <= {req_addr_q[WORD_ADDR_BITS-1:4], 2'b00};
                        end
                    end
                end
                WB_CMD: begin
                    if (mem_req_ready) begin
                        mem_req_valid      <= 1'b0;
                        mem_req_data_valid <= 1'b1;
                        mem_req_data_bits  <= data_q[vic_q][req_idx][0];
                        mem_req_data_mask  <= 16'hFFFF;
                        beat_cnt           <= '0;
                        state              <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (mem_req_data_ready) begin
                        if (beat_cnt == 2'd3) begin
                            mem_req_data_valid <= 1'b0;
                            mem_req_data_bits  <= '0;
                            mem_req_data_mask  <= '0;
                            beat_cnt           <= '0;
                            mem_req_valid      <= 1'b1;
                            mem_req_rw         <= 1'b0;
                            mem_req_addr <= {req_addr_q[WORD_ADDR_BITS-1:4], 2'b00};
                            state              <= FILL_CMD;
                        end else begin
                            beat_cnt          <= beat_cnt + 2'd1;
                            mem_req_data_bits <= data_q[vic_q][req_idx][beat_cnt + 2'd1];
                        end
                    end
                end
                FILL_CMD: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    if (mem_resp_valid) begin
                        data_q[vic_q][req_idx][beat_cnt] <= mem_resp_data;
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            tag_q[vic_q][req_idx]   <= req_tag;
                            valid_q[req_idx][vic_q] <= 1'b1;
                            dirty_q[req_idx][vic_q] <= 1'b0;
                            state                   <= REPLAY;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef WB_CACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (state == LOOKUP && hit)        perf_hits       <= perf_hits + 1'b1;
            if (state == LOOKUP && !hit)       perf_misses     <= perf_misses + 1'b1;
            if (state == WB_CMD && mem_req_ready) perf_writebacks <= perf_writebacks + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_cache.sv
// Directed bench for wb_cache: behavioural memory responder plus a linear CPU script.
module tb_wb_cache;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req_valid, cpu_req_ready;
    logic [29:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic [3:0]   cpu_req_write;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    wb_cache dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_req_write(cpu_req_write),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmd_stall = 0, data_stall = 0;
    int rd_cmds = 0, wr_cmds = 0, wr_beats = 0;
    int rd_beat = -1, last_beat_cyc = 0;
    logic [27:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [127:0] wr_log [4];
    logic [127:0] mem [logic [27:0]];

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Memory word at word address W holds 32'h8000_0000 | W unless written back.
    function automatic logic [127:0] pat(input logic [27:0] a);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[32*k +: 32] = 32'h8000_0000 | {2'b00, a, 2'(k)};
        return v;
    endfunction

    function automatic logic [127:0] mem_rd(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    task automatic serve();
        logic        rw;
        logic [27:0] a;
        logic [144:0] snap;
        int k;
        rw = mem_req_rw;
        a  = mem_req_addr;
        repeat (cmd_stall) begin
            @(negedge clk);
            if (reset) return;
            check("cmd_hold", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, rw, a});
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (reset) return;
        if (rw) begin
            wr_cmds++;
            last_wr_addr = a;
            for (int b = 0; b < 4; b++) begin
                k = 0;
                while (!mem_req_data_valid && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                if (reset) return;
                check("wb_valid", mem_req_data_valid, 1'b1);
                check("wb_mask", mem_req_data_mask, 16'hFFFF);
                snap = {mem_req_data_valid, mem_req_data_mask, mem_req_data_bits};
                repeat (data_stall) begin
                    @(negedge clk);
                    if (reset) return;
                    check("wb_data_hold",
                          {mem_req_data_valid, mem_req_data_mask, mem_req_data_bits}, snap);
                end
                wr_log[b] = mem_req_data_bits;
                mem[a + 28'(b)] = mem_req_data_bits;
                wr_beats++;
                mem_req_data_ready = 1'b1;
                @(negedge clk);
                mem_req_data_ready = 1'b0;
                if (reset) return;
            end
        end else begin
            rd_cmds++;
            last_rd_addr = a;
            for (int b = 0; b < 4; b++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rd(a + 28'(b));
                rd_beat        = b;
                last_beat_cyc  = cyc;
                @(negedge clk);
                if (reset) break;
            end
            mem_resp_valid = 1'b0;
            rd_beat        = -1;
        end
    endtask

    initial begin
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_req_valid) serve();
        end
    end

    task automatic cpu_op(input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] we, output logic [31:0] rd,
                          output int lat, output int rc);
        int k;
        k = 0;
        while (!cpu_req_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_data  = d;
        cpu_req_write = we;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        lat = 1;
        while (!(we == 4'b0 ? cpu_resp_valid : cpu_req_ready) && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        rd = cpu_resp_data;
        rc = cyc;
    endtask

    task automatic init_wait(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_req_ready && n < 100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        logic [127:0] e;
        int lat, rc, n, r0, w0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        cpu_req_write = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cpu_req_ready, cpu_resp_valid, cpu_resp_data,
              mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid,
              mem_req_data_mask}, '0);
        check("reset_bits", mem_req_data_bits, '0);
        reset = 1'b0;
        init_wait(n);
        check("init_cycles", n, 32);

        cpu_op(30'h100, 32'h0, 4'b0000, rd, lat, rc);
        check("cold_data", rd, 32'h8000_0100);
        check("cold_rd_addr", last_rd_addr, 28'h40);
        check("cold_rd_cmds", rd_cmds, 1);
        check("cold_lat", rc - last_beat_cyc, 2);

        cpu_op(30'h100, 32'h0, 4'b0000, rd, lat, rc);
        check("hit_data", rd, 32'h8000_0100);
        check("hit_lat", lat, 2);
        check("hit_no_mem", rd_cmds, 1);

        cpu_op(30'h100, 32'hDEAD_BEEF, 4'b0011, rd, lat, rc);
        check("st_lat", lat, 2);
        cpu_op(30'h100, 32'h0, 4'b0000, rd, lat, rc);
        check("st_merge", rd, 32'h8000_BEEF);
        check("st_no_mem", {32'(rd_cmds), 32'(wr_cmds)}, {32'd1, 32'd0});

        cpu_op(30'h000, 32'h0, 4'b0000, rd, lat, rc);
        check("set0_a", rd, 32'h8000_0000);
        cpu_op(30'h003, 32'h1234_5678, 4'b1111, rd, lat, rc);
        cpu_op(30'h200, 32'h0, 4'b0000, rd, lat, rc);
        check("set0_b", rd, 32'h8000_0200);
        cpu_op(30'h200, 32'h0, 4'b0000, rd, lat, rc);
        check("set0_b_hit", lat, 2);
        r0 = rd_cmds;
        w0 = wr_cmds;
        cmd_stall  = 5;
        data_stall = 5;
        cpu_op(30'h400, 32'h0, 4'b0000, rd, lat, rc);
        check("evict_data", rd, 32'h8000_0400);
        check("evict_wr_cmds", wr_cmds, w0 + 1);
        check("evict_wr_addr", last_wr_addr, 28'h0);
        check("evict_wr_beats", wr_beats, 4);
        e = pat(28'h0);
        e[127:96] = 32'h1234_5678;
        check("wb_beat0", wr_log[0], e);
        check("wb_beat1", wr_log[1], pat(28'h1));
        check("wb_beat2", wr_log[2], pat(28'h2));
        check("wb_beat3", wr_log[3], pat(28'h3));
        check("evict_rd_addr", last_rd_addr, 28'h100);
        check("evict_rd_cmds", rd_cmds, r0 + 1);
        cmd_stall  = 0;
        data_stall = 0;
        cpu_op(30'h003, 32'h0, 4'b0000, rd, lat, rc);
        check("reload_wb_data", rd, 32'h1234_5678);
        check("reload_no_wb", wr_cmds, w0 + 1);

        r0 = rd_cmds;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 30'h1050;
        cpu_req_write = 4'b0000;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 0;
        while (rd_beat != 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        check("rst_at_beat2", rd_beat, 2);
        @(negedge clk);
        check("rst_mid_outputs", {cpu_req_ready, cpu_resp_valid, cpu_resp_data,
              mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid,
              mem_req_data_mask}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        init_wait(n);
        check("reinit_cycles", n, 32);
        cpu_op(30'h1050, 32'h0, 4'b0000, rd, lat, rc);
        check("post_rst_data", rd, 32'h8000_1050);
        check("post_rst_miss", rd_cmds, r0 + 2);
        check("post_rst_rd_addr", last_rd_addr, 28'h414);
        check("post_rst_no_wb", wr_cmds, w0 + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
